// File: rtl/mem_access.sv
// Memory-access pipeline stage: drives the data bus for LOAD/STORE using req/ack,
// and registers everything write-back needs. Non-memory ops pass through in one cycle.
module mem_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [6:0]  ex_opcode,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_res,
  input  logic [31:0] ex_store_data,
  input  logic [31:0] ex_pc,
  input  logic [4:0]  ex_rd,
  output logic        d_req,
  output logic [31:0] d_address,
  output logic        d_write_enable,
  output logic [3:0]  d_byte_enable,
  output logic [31:0] d_data_write,
  input  logic        d_ack,
  input  logic [31:0] d_data_read,
  output logic        wb_valid,
  output logic [31:0] wb_res,
  output logic [31:0] wb_pc,
  output logic [6:0]  wb_opcode,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_d_data_read,
  output logic [1:0]  wb_load_shift,
  output logic [1:0]  wb_load_size,
  output logic        wb_load_sign_extend,
  output logic        wb_misaligned
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;

  logic        is_load, is_store, is_mem, misaligned;
  logic [3:0]  be_next;
  logic [31:0] data_next;

  assign ex_ready = (state == IDLE);

  // funct3[1:0] == 2'b11 falls into the word case for both alignment and lanes.
  always_comb begin
    is_load    = (ex_opcode == OP_LOAD);
    is_store   = (ex_opcode == OP_STORE);
    is_mem     = is_load | is_store;
    misaligned = 1'b0;
    be_next    = 4'b1111;
    data_next  = ex_store_data;
    case (ex_funct3[1:0])
      2'b00: begin
        be_next   = 4'b0001 << ex_res[1:0];
        data_next = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        misaligned = ex_res[0];
        be_next    = 4'b0011 << ex_res[1:0];
        data_next  = {2{ex_store_data[15:0]}};
      end
      default: misaligned = (ex_res[1:0] != 2'b00);
    endcase
    if (is_load) be_next = 4'b1111;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      d_req               <= 1'b0;
      d_address           <= '0;
      d_write_enable      <= 1'b0;
      d_byte_enable       <= '0;
      d_data_write        <= '0;
      wb_valid            <= 1'b0;
      wb_res              <= '0;
      wb_pc               <= '0;
      wb_opcode           <= '0;
      wb_rd               <= '0;
      wb_d_data_read      <= '0;
      wb_load_shift       <= '0;
      wb_load_size        <= '0;
      wb_load_sign_extend <= 1'b0;
      wb_misaligned       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wb_valid <= 1'b0;
          if (ex_valid) begin
            wb_res              <= ex_res;
            wb_pc               <= ex_pc;
            wb_opcode           <= ex_opcode;
            wb_load_shift       <= ex_res[1:0];
            wb_load_size        <= ex_funct3[1:0];
            wb_load_sign_extend <= ~ex_funct3[2];
            wb_misaligned       <= is_mem & misaligned;
            wb_rd               <= (is_store | (is_mem & misaligned)) ? '0 : ex_rd;
            if (is_mem && !misaligned) begin
              state          <= BUSY;
              d_req          <= 1'b1;
              d_address      <= {ex_res[31:2], 2'b00};
              d_write_enable <= is_store;
              d_byte_enable  <= be_next;
              d_data_write   <= data_next;
            end else begin
              wb_valid <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (d_ack) begin
            state          <= IDLE;
            d_req          <= 1'b0;
            wb_d_data_read <= d_data_read;
            wb_valid       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: reset/abort, ALU pass-through,
// loads and stores with bus handshakes, and misaligned accesses.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_res;
  logic [31:0] ex_store_data;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rd;
  logic        d_req;
  logic [31:0] d_address;
  logic        d_write_enable;
  logic [3:0]  d_byte_enable;
  logic [31:0] d_data_write;
  logic        d_ack;
  logic [31:0] d_data_read;
  logic        wb_valid;
  logic [31:0] wb_res;
  logic [31:0] wb_pc;
  logic [6:0]  wb_opcode;
  logic [4:0]  wb_rd;
  logic [31:0] wb_d_data_read;
  logic [1:0]  wb_load_shift;
  logic [1:0]  wb_load_size;
  logic        wb_load_sign_extend;
  logic        wb_misaligned;

  int unsigned total = 0;
  int unsigned bad   = 0;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_res(ex_res),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .d_req(d_req), .d_address(d_address), .d_write_enable(d_write_enable),
    .d_byte_enable(d_byte_enable), .d_data_write(d_data_write), .d_ack(d_ack),
    .d_data_read(d_data_read), .wb_valid(wb_valid), .wb_res(wb_res), .wb_pc(wb_pc),
    .wb_opcode(wb_opcode), .wb_rd(wb_rd), .wb_d_data_read(wb_d_data_read),
    .wb_load_shift(wb_load_shift), .wb_load_size(wb_load_size),
    .wb_load_sign_extend(wb_load_sign_extend), .wb_misaligned(wb_misaligned)
  );

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                       input logic [31:0] sd, input logic [31:0] pc, input logic [4:0] rd);
    ex_valid = 1'b1; ex_opcode = op; ex_funct3 = f3; ex_res = res;
    ex_store_data = sd; ex_pc = pc; ex_rd = rd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total++; if (d_req !== 1'b0) begin bad++; $display("FAIL rst_req act=%b exp=0", d_req); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wbv act=%b exp=0", wb_valid); end
    total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL rst_ready act=%b exp=1", ex_ready); end
    total++; if (d_byte_enable !== 4'b0000) begin bad++; $display("FAIL rst_be act=%b exp=0000", d_byte_enable); end
    total++; if (d_address !== 32'h0) begin bad++; $display("FAIL rst_addr act=%h exp=0", d_address); end
    total++; if (wb_res !== 32'h0 || wb_rd !== 5'd0 || wb_misaligned !== 1'b0) begin
      bad++; $display("FAIL rst_wb act=%h/%0d/%b exp=0/0/0", wb_res, wb_rd, wb_misaligned); end
    // Start an aligned LW, then abort it with reset while BUSY.
    issue(OP_LOAD, 3'b010, 32'h100, 32'h0, 32'h40, 5'd3);
    tick();
    ex_valid = 1'b0;
    total++; if (d_req !== 1'b1 || ex_ready !== 1'b0) begin
      bad++; $display("FAIL abort_busy act=req%b rdy%b exp=req1 rdy0", d_req, ex_ready); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (d_req !== 1'b0 || wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
      bad++; $display("FAIL abort_reset act=req%b wbv%b rdy%b exp=req0 wbv0 rdy1", d_req, wb_valid, ex_ready); end
    d_ack = 1'b1; d_data_read = 32'hDEADBEEF;
    tick();
    d_ack = 1'b0;
    total++; if (d_req !== 1'b0 || wb_valid !== 1'b0 || wb_d_data_read !== 32'h0 || ex_ready !== 1'b1) begin
      bad++; $display("FAIL stray_ack act=req%b wbv%b rd=%h exp=req0 wbv0 rd=0", d_req, wb_valid, wb_d_data_read); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      issue(OP_ALU, 3'b000, vals[i], 32'h0, 32'h200 + 32'(4 * i), 5'd5 + 5'(i));
      tick();
      total++; if (wb_valid !== 1'b1 || wb_res !== vals[i] || d_req !== 1'b0) begin
        bad++; $display("FAIL b2b_%0d act=v%b res=%h req%b exp=v1 res=%h req0", i, wb_valid, wb_res, d_req, vals[i]); end
      total++; if (wb_rd !== 5'd5 + 5'(i) || wb_pc !== 32'h200 + 32'(4 * i) || wb_opcode !== OP_ALU) begin
        bad++; $display("FAIL b2b_fields_%0d act=rd%0d pc=%h op=%b", i, wb_rd, wb_pc, wb_opcode); end
    end
    ex_valid = 1'b0;
    tick();
    total++; if (wb_valid !== 1'b0 || wb_res !== 32'h33) begin
      bad++; $display("FAIL b2b_hold act=v%b res=%h exp=v0 res=00000033", wb_valid, wb_res); end
  endtask

  task automatic test_lb();
    issue(OP_LOAD, 3'b000, 32'h1003, 32'h0, 32'h80, 5'd7);
    tick();
    ex_valid = 1'b0;
    total++; if (d_req !== 1'b1 || d_address !== 32'h1000 || d_byte_enable !== 4'b1111 || d_write_enable !== 1'b0) begin
      bad++; $display("FAIL lb_bus act=req%b addr=%h be=%b we=%b exp=req1 addr=00001000 be=1111 we=0",
                      d_req, d_address, d_byte_enable, d_write_enable); end
    total++; if (ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL lb_busy act=rdy%b wbv%b exp=rdy0 wbv0", ex_ready, wb_valid); end
    tick();
    total++; if (d_req !== 1'b1 || wb_valid !== 1'b0 || d_address !== 32'h1000) begin
      bad++; $display("FAIL lb_wait act=req%b wbv%b addr=%h exp=req1 wbv0", d_req, wb_valid, d_address); end
    tick();
    d_ack = 1'b1; d_data_read = 32'h80FFFFFF;
    tick();
    d_ack = 1'b0; d_data_read = 32'h0;
    total++; if (wb_valid !== 1'b1 || d_req !== 1'b0 || ex_ready !== 1'b1) begin
      bad++; $display("FAIL lb_done act=wbv%b req%b rdy%b exp=wbv1 req0 rdy1", wb_valid, d_req, ex_ready); end
    total++; if (wb_load_shift !== 2'd3 || wb_load_size !== 2'd0 || wb_load_sign_extend !== 1'b1) begin
      bad++; $display("FAIL lb_ctrl act=sh%0d sz%0d se%b exp=sh3 sz0 se1", wb_load_shift, wb_load_size, wb_load_sign_extend); end
    total++; if (wb_d_data_read !== 32'h80FFFFFF || wb_rd !== 5'd7 || wb_res !== 32'h1003 || wb_pc !== 32'h80) begin
      bad++; $display("FAIL lb_wb act=rd=%h rd%0d res=%h pc=%h exp=80ffffff 7 00001003 00000080",
                      wb_d_data_read, wb_rd, wb_res, wb_pc); end
    tick();
    total++; if (wb_valid !== 1'b0 || wb_d_data_read !== 32'h80FFFFFF) begin
      bad++; $display("FAIL lb_pulse act=wbv%b rd=%h exp=wbv0 rd=80ffffff", wb_valid, wb_d_data_read); end
  endtask

  // Store with immediate ack; checks bus lanes then completion.
  task automatic run_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [3:0] exp_be, input logic [31:0] exp_data);
    issue(OP_STORE, f3, addr, sd, 32'h300, 5'd9);
    tick();
    ex_valid = 1'b0;
    total++; if (d_req !== 1'b1 || d_write_enable !== 1'b1 || d_byte_enable !== exp_be ||
                 d_data_write !== exp_data || d_address !== {addr[31:2], 2'b00}) begin
      bad++; $display("FAIL %s_bus act=req%b we%b be=%b data=%h addr=%h exp=req1 we1 be=%b data=%h",
                      name, d_req, d_write_enable, d_byte_enable, d_data_write, d_address, exp_be, exp_data); end
    d_ack = 1'b1;
    tick();
    d_ack = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_rd !== 5'd0 || wb_misaligned !== 1'b0 || d_req !== 1'b0) begin
      bad++; $display("FAIL %s_done act=wbv%b rd%0d mis%b req%b exp=wbv1 rd0 mis0 req0",
                      name, wb_valid, wb_rd, wb_misaligned, d_req); end
  endtask

  task automatic test_stores();
    run_store("sh", 3'b001, 32'h2002, 32'hABCD1234, 4'b1100, 32'h12341234);
    run_store("sb", 3'b000, 32'h3001, 32'h000000EE, 4'b0010, 32'hEEEEEEEE);
    run_store("sw", 3'b010, 32'h6000, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
  endtask

  task automatic test_lhu();
    issue(OP_LOAD, 3'b101, 32'h5002, 32'h0, 32'h500, 5'd12);
    tick();
    ex_valid = 1'b0;
    total++; if (d_req !== 1'b1 || d_address !== 32'h5000 || d_byte_enable !== 4'b1111) begin
      bad++; $display("FAIL lhu_bus act=req%b addr=%h be=%b exp=req1 00005000 1111", d_req, d_address, d_byte_enable); end
    d_ack = 1'b1; d_data_read = 32'h1234ABCD;
    tick();
    d_ack = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_load_shift !== 2'd2 || wb_load_size !== 2'd1 ||
                 wb_load_sign_extend !== 1'b0 || wb_d_data_read !== 32'h1234ABCD || wb_rd !== 5'd12) begin
      bad++; $display("FAIL lhu_done act=wbv%b sh%0d sz%0d se%b rd=%h rd%0d exp=wbv1 sh2 sz1 se0 1234abcd 12",
                      wb_valid, wb_load_shift, wb_load_size, wb_load_sign_extend, wb_d_data_read, wb_rd); end
  endtask

  task automatic test_misaligned();
    issue(OP_LOAD, 3'b010, 32'h4002, 32'h0, 32'h400, 5'd4);
    tick();
    ex_valid = 1'b0;
    total++; if (d_req !== 1'b0 || wb_valid !== 1'b1 || wb_misaligned !== 1'b1 || wb_rd !== 5'd0 || ex_ready !== 1'b1) begin
      bad++; $display("FAIL lw_mis act=req%b wbv%b mis%b rd%0d rdy%b exp=req0 wbv1 mis1 rd0 rdy1",
                      d_req, wb_valid, wb_misaligned, wb_rd, ex_ready); end
    issue(OP_STORE, 3'b001, 32'h5001, 32'h0, 32'h404, 5'd6);
    tick();
    ex_valid = 1'b0;
    total++; if (d_req !== 1'b0 || wb_valid !== 1'b1 || wb_misaligned !== 1'b1 || wb_res !== 32'h5001) begin
      bad++; $display("FAIL sh_mis act=req%b wbv%b mis%b res=%h exp=req0 wbv1 mis1 00005001",
                      d_req, wb_valid, wb_misaligned, wb_res); end
    tick();
    total++; if (d_req !== 1'b0 || wb_valid !== 1'b0 || wb_misaligned !== 1'b1) begin
      bad++; $display("FAIL mis_idle act=req%b wbv%b mis%b exp=req0 wbv0 mis1", d_req, wb_valid, wb_misaligned); end
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_opcode = '0; ex_funct3 = '0; ex_res = '0;
    ex_store_data = '0; ex_pc = '0; ex_rd = '0; d_ack = 1'b0; d_data_read = '0;
    test_reset();
    test_back_to_back();
    test_lb();
    test_stores();
    test_lhu();
    test_misaligned();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
